// File: rtl/vga_timing_pkg.sv
// Shared raster timing types and constants: phase encoding, default 640x480@60
// timing, position width, and the sync polarity helper.
package vga_timing_pkg;

  localparam int POS_W  = 10;
  localparam int FCNT_W = 8;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  typedef enum logic [1:0] {
    PH_ACT = 2'd0,
    PH_FP  = 2'd1,
    PH_SYN = 2'd2,
    PH_BP  = 2'd3
  } phase_e;

  // Pin level for a sync pulse given whether it is asserted and its polarity.
  function automatic logic sync_level(input logic asserted, input logic active_low);
    return asserted ^ active_low;
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Raster timing bundle driven by vga_timing_ctrl toward the pixel pipeline.
// master = timing generator, slave = pixel datapath consumer.
interface vga_timing_ctrl_if;
  import vga_timing_pkg::*;

  logic              hsync;
  logic              vsync;
  logic              display_on;
  logic [POS_W-1:0]  hpos;
  logic [POS_W-1:0]  vpos;
  logic              line_start;
  logic              frame_start;
  logic              prefetch;
  logic [FCNT_W-1:0] frame_cnt;

  modport master (
    output hsync, vsync, display_on, hpos, vpos,
    output line_start, frame_start, prefetch, frame_cnt
  );

  modport slave (
    input hsync, vsync, display_on, hpos, vpos,
    input line_start, frame_start, prefetch, frame_cnt
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACT/FP/SYN/BP phase FSM, advancing on step_i once started.
// Exposes registered position and the next-state position/phase so the parent can register decodes in step.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FRONT  = DEF_H_FRONT,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BACK   = DEF_H_BACK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_i,
  input  logic             started_i,
  output logic [POS_W-1:0] pos_o,
  output logic [POS_W-1:0] pos_nxt_o,
  output phase_e           phase_nxt_o,
  output logic             wrap_o
);

  localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;

  localparam logic [POS_W-1:0] LAST_ACT = POS_W'(ACTIVE - 1);
  localparam logic [POS_W-1:0] LAST_FP  = POS_W'(ACTIVE + FRONT - 1);
  localparam logic [POS_W-1:0] LAST_SYN = POS_W'(ACTIVE + FRONT + SYNC - 1);
  localparam logic [POS_W-1:0] LAST     = POS_W'(TOTAL - 1);

  logic [POS_W-1:0] pos_q, pos_d;
  phase_e           phase_q, phase_d;
  logic             adv;

  assign adv    = step_i & started_i;
  assign wrap_o = adv & (pos_q == LAST);

  // Phase transitions are keyed on the last position of each segment.
  always_comb begin
    pos_d   = pos_q;
    phase_d = phase_q;
    if (adv) begin
      pos_d = (pos_q == LAST) ? '0 : pos_q + POS_W'(1);
      case (phase_q)
        PH_ACT: if (pos_q == LAST_ACT) phase_d = PH_FP;
        PH_FP:  if (pos_q == LAST_FP)  phase_d = PH_SYN;
        PH_SYN: if (pos_q == LAST_SYN) phase_d = PH_BP;
        PH_BP:  if (pos_q == LAST)     phase_d = PH_ACT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q   <= '0;
      phase_q <= PH_ACT;
    end else begin
      pos_q   <= pos_d;
      phase_q <= phase_d;
    end
  end

  assign pos_o       = pos_q;
  assign pos_nxt_o   = pos_d;
  assign phase_nxt_o = phase_d;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: syncs, display window, coordinates, strobes and LEAD-clock prefetch; all outputs
// registered with zero latency to the counters, free-running with no backpressure. Option: VGA_FRAME_CNT_EN.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE        = DEF_H_ACTIVE,
  parameter int H_FRONT         = DEF_H_FRONT,
  parameter int H_SYNC          = DEF_H_SYNC,
  parameter int H_BACK          = DEF_H_BACK,
  parameter int V_ACTIVE        = DEF_V_ACTIVE,
  parameter int V_FRONT         = DEF_V_FRONT,
  parameter int V_SYNC          = DEF_V_SYNC,
  parameter int V_BACK          = DEF_V_BACK,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int LEAD            = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_timing_ctrl_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [POS_W:0]   H_TOTAL_X  = (POS_W+1)'(H_TOTAL);
  localparam logic [POS_W:0]   H_ACTIVE_X = (POS_W+1)'(H_ACTIVE);
  localparam logic [POS_W:0]   LEAD_X     = (POS_W+1)'(LEAD);
  localparam logic [POS_W-1:0] V_LAST     = POS_W'(V_TOTAL - 1);
  localparam logic [POS_W-1:0] V_ACTIVE_W = POS_W'(V_ACTIVE);
  localparam logic [POS_W-1:0] PF_RESUME  = POS_W'((LEAD < H_ACTIVE) ? (H_ACTIVE - LEAD) : 0);
  localparam logic             SYNC_LOW   = (SYNC_ACTIVE_LOW != 0);

  logic             started_q;
  logic [POS_W-1:0] hpos_q, hpos_d, vpos_q, vpos_d;
  phase_e           hph_d, vph_d;
  logic             h_wrap, v_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT),
    .SYNC   (H_SYNC),
    .BACK   (H_BACK)
  ) u_hcnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .step_i      (1'b1),
    .started_i   (started_q),
    .pos_o       (hpos_q),
    .pos_nxt_o   (hpos_d),
    .phase_nxt_o (hph_d),
    .wrap_o      (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT),
    .SYNC   (V_SYNC),
    .BACK   (V_BACK)
  ) u_vcnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .step_i      (h_wrap),
    .started_i   (started_q),
    .pos_o       (vpos_q),
    .pos_nxt_o   (vpos_d),
    .phase_nxt_o (vph_d),
    .wrap_o      (v_wrap)
  );

  // Position LEAD clocks past the next counter value; LEAD never exceeds the blanking width, so one wrap suffices.
  logic [POS_W:0]   h_ahead;
  logic [POS_W-1:0] v_ahead;
  logic             ahead_vis;

  always_comb begin
    h_ahead = {1'b0, hpos_d} + LEAD_X;
    v_ahead = vpos_d;
    if (h_ahead >= H_TOTAL_X) begin
      h_ahead = h_ahead - H_TOTAL_X;
      v_ahead = (vpos_d == V_LAST) ? '0 : vpos_d + POS_W'(1);
    end
    ahead_vis = (h_ahead < H_ACTIVE_X) && (v_ahead < V_ACTIVE_W);
  end

  // Nothing fetched the start of line 0 before startup, so prefetch stays off until that line's pre-roll has passed.
  logic pf_arm_q, pf_arm_d;
  assign pf_arm_d = pf_arm_q | (started_q & (hpos_d >= PF_RESUME));

  logic hsync_q, vsync_q, display_on_q, line_start_q, frame_start_q, prefetch_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started_q     <= 1'b0;
      pf_arm_q      <= 1'b0;
      hsync_q       <= sync_level(1'b0, SYNC_LOW);
      vsync_q       <= sync_level(1'b0, SYNC_LOW);
      display_on_q  <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      prefetch_q    <= 1'b0;
    end else begin
      started_q     <= 1'b1;
      pf_arm_q      <= pf_arm_d;
      hsync_q       <= sync_level(hph_d == PH_SYN, SYNC_LOW);
      vsync_q       <= sync_level(vph_d == PH_SYN, SYNC_LOW);
      display_on_q  <= (hph_d == PH_ACT) && (vph_d == PH_ACT);
      line_start_q  <= h_wrap | ~started_q;
      frame_start_q <= v_wrap | ~started_q;
      prefetch_q    <= pf_arm_d & ahead_vis;
    end
  end

  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.display_on  = display_on_q;
  assign vga.hpos        = hpos_q;
  assign vga.vpos        = vpos_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
  assign vga.prefetch    = prefetch_q;

`ifdef VGA_FRAME_CNT_EN
  // v_wrap marks every frame start except the one produced by startup.
  logic [FCNT_W-1:0] frame_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else if (v_wrap) begin
      frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
    end
  end

  assign vga.frame_cnt = frame_cnt_q;
`else
  assign vga.frame_cnt = '0;
`endif

endmodule
